// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared state type, block width and round-robin helper for aes_job_scheduler
package aes_sched_pkg;
  localparam int AES_BLK_W = 128;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
  function automatic int rr_next(int ptr, int n);
    return (ptr + 1) % n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);
  logic [ID_W-1:0] cand;
  // Walk candidates from farthest to nearest so the nearest set request wins
  always_comb begin
    idx_o = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) idx_o = cand;
    end
  end
  assign any_o = |req_i;
  assign grant_o = any_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_o) : '0;
endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one AES-128 core among requesters; AES_SCHED_TIMEOUT_EN adds a WAIT watchdog
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int TIMEOUT = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_data_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_key_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         core_start_o,
  output logic [AES_BLK_W-1:0]         core_data_o,
  output logic [AES_BLK_W-1:0]         core_key_o,
  input  logic                         core_done_i,
  input  logic [AES_BLK_W-1:0]         core_result_i,
  output logic                         rsp_valid_o,
  output logic [ID_W-1:0]              rsp_id_o,
  output logic [AES_BLK_W-1:0]         rsp_data_o,
  input  logic                         rsp_ready_i,
  output logic                         busy_o,
  output logic                         timeout_err_o
);
  sched_state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, cur_id_q, rsp_id_q, gnt_idx;
  logic [AES_BLK_W-1:0] core_data_q, core_key_q, rsp_data_q;
  logic [NUM_REQ-1:0] gnt;
  logic any_req, tmo;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i(req_valid_i),
    .ptr_i(rr_ptr_q),
    .grant_o(gnt),
    .idx_o(gnt_idx),
    .any_o(any_req)
  );
  // State register
  always_ff @(posedge clk) state_q <= !reset ? IDLE : state_d;
  // Next state: one job walks IDLE -> ISSUE -> WAIT -> RESP and back
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (core_done_i || tmo) ? RESP : WAIT;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decoded from state; the grant is only exposed while idle
  always_comb begin
    req_ready_o = (state_q == IDLE) ? gnt : '0;
    core_start_o = state_q == ISSUE;
    rsp_valid_o = state_q == RESP;
    busy_o = state_q != IDLE;
  end
  // Capture the job on grant and the result on completion or timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      core_data_q <= '0;
      core_key_q <= '0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        core_data_q <= req_data_i[gnt_idx*AES_BLK_W +: AES_BLK_W];
        core_key_q <= req_key_i[gnt_idx*AES_BLK_W +: AES_BLK_W];
        cur_id_q <= gnt_idx;
        rr_ptr_q <= ID_W'(rr_next(int'(gnt_idx), NUM_REQ));
      end
      if (state_q == WAIT && (core_done_i || tmo)) begin
        rsp_data_q <= core_done_i ? core_result_i : '0;
        rsp_id_q <= cur_id_q;
      end
    end
  end
  assign core_data_o = core_data_q;
  assign core_key_o = core_key_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_id_o = rsp_id_q;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic err_q;
  // Count cycles spent in WAIT; held at zero elsewhere so each WAIT starts fresh
  always_ff @(posedge clk) cnt_q <= (!reset || state_q != WAIT) ? '0 : cnt_q + 1'b1;
  // A done on the expiry cycle takes priority, so the error only fires without one
  assign tmo = state_q == WAIT && !core_done_i && cnt_q == CNT_W'(TIMEOUT - 1);
  // Sticky error flag
  always_ff @(posedge clk) err_q <= !reset ? 1'b0 : (err_q | tmo);
  assign timeout_err_o = err_q;
`else
  assign tmo = 1'b0;
  assign timeout_err_o = TIMEOUT < 0;
`endif
endmodule
